// File: rtl/dft_framer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dft_framer_pkg
// Description : Shared types and constants for the DFT sink framer and the
//               size-code lookup. Holds the framer state encoding, the
//               36-entry size-code to point-count table, the largest legal
//               size code and the point-count width.
// Revision    : 1.0 - initial release
// ============================================================================
package dft_framer_pkg;

   localparam int PTS_W     = 11;
   localparam int NUM_SIZES = 36;

   // Largest legal size code; anything above is rejected with err_size.
   localparam logic [5:0] SIZE_MAX = 6'd35;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   // Supported transform lengths, ascending by size code.
   localparam logic [PTS_W-1:0] SIZE_PTS [0:NUM_SIZES-1] = '{
      11'd12,   11'd24,   11'd36,   11'd48,   11'd60,   11'd72,
      11'd96,   11'd108,  11'd120,  11'd144,  11'd180,  11'd192,
      11'd216,  11'd240,  11'd288,  11'd300,  11'd324,  11'd360,
      11'd384,  11'd432,  11'd480,  11'd540,  11'd576,  11'd600,
      11'd648,  11'd720,  11'd768,  11'd864,  11'd900,  11'd960,
      11'd972,  11'd1080, 11'd1152, 11'd1200, 11'd1296, 11'd1536
   };

endpackage : dft_framer_pkg
`default_nettype wire

// File: rtl/dft_size_lut.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dft_size_lut
// Description : Combinational size-code decoder. Maps a 6-bit size code to
//               its DFT point count and flags whether the code is legal.
//               Illegal codes return a point count of zero.
// Ports       : code  - size code in
//               pts   - point count out (PTS_W bits)
//               legal - high when code <= SIZE_MAX
// Revision    : 1.0 - initial release
// ============================================================================
module dft_size_lut
   import dft_framer_pkg::*;
(
   input  logic [5:0]       code,
   output logic [PTS_W-1:0] pts,
   output logic             legal
);

   always_comb begin
      legal = (code <= SIZE_MAX);
      pts   = '0;
      if (legal) begin
         pts = SIZE_PTS[code];
      end
   end

endmodule : dft_size_lut
`default_nettype wire

// File: rtl/dft_sink_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dft_sink_framer
// Description : Transmit-side framer for the mixed-radix DFT sink interface.
//               Accepts a frame request (size code + inverse flag), pulls
//               exactly pts samples from an upstream valid/ready stream,
//               presents them as one sop..eop frame through a single output
//               register stage that honours sink_ready, then holds off the
//               next request for a minimum inter-frame gap.
// Parameters  : DW      - sample component width
//               GAP_MIN - idle cycles after the eop handshake (0..255)
// Ports       : clk, rst_n (synchronous, active-low)
//               req_valid/req_ready/req_size/req_inverse - frame request
//               in_valid/in_ready/in_real/in_imag        - upstream samples
//               in_last                                  - early end (option)
//               sink_valid/sink_ready/sink_sop/sink_eop/
//               sink_real/sink_imag                      - to the DFT core
//               size, inverse - latched request fields for the DFT
//               busy          - framer not idle
//               err_size      - one-cycle pulse on an illegal size code
// Options     : DFT_FRAMER_PAD_EN - adds in_last; an early in_last makes the
//               framer zero-pad the rest of the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module dft_sink_framer
   import dft_framer_pkg::*;
#(
   parameter int DW      = 18,
   parameter int GAP_MIN = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [5:0]    req_size,
   input  logic          req_inverse,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_real,
   input  logic [DW-1:0] in_imag,
`ifdef DFT_FRAMER_PAD_EN
   input  logic          in_last,
`endif
   output logic          sink_valid,
   input  logic          sink_ready,
   output logic          sink_sop,
   output logic          sink_eop,
   output logic [DW-1:0] sink_real,
   output logic [DW-1:0] sink_imag,
   output logic [5:0]    size,
   output logic          inverse,
   output logic          busy,
   output logic          err_size
);

   localparam logic [7:0] GAP_LOAD = 8'(GAP_MIN);

   state_e           state_q,      state_d;
   logic [PTS_W-1:0] pts_q,        pts_d;
   logic [PTS_W-1:0] count_q,      count_d;
   logic [5:0]       size_q,       size_d;
   logic             inverse_q,    inverse_d;
   logic             sink_valid_q, sink_valid_d;
   logic             sink_sop_q,   sink_sop_d;
   logic             sink_eop_q,   sink_eop_d;
   logic [DW-1:0]    sink_real_q,  sink_real_d;
   logic [DW-1:0]    sink_imag_q,  sink_imag_d;
   logic [7:0]       gap_q,        gap_d;
   logic             err_size_q,   err_size_d;
   logic             pad_q,        pad_d;
   logic             req_ready_q,  req_ready_d;

   logic [PTS_W-1:0] lut_pts;
   logic             lut_legal;
   logic             last_flag;
   logic             out_free;
   logic             in_hs;
   logic             take;
   logic             is_last;

   dft_size_lut u_size_lut (
      .code  (req_size),
      .pts   (lut_pts),
      .legal (lut_legal)
   );

`ifdef DFT_FRAMER_PAD_EN
   assign last_flag = in_last;
`else
   assign last_flag = 1'b0;
`endif

   // The output register can take a new beat when empty or being drained.
   assign out_free = !sink_valid_q || sink_ready;
   assign in_ready = (state_q == ST_SEND) && !pad_q && out_free;
   assign in_hs    = in_valid && in_ready;
   // A beat is loaded either from upstream or, while padding, as a zero.
   assign take     = in_hs || ((state_q == ST_SEND) && pad_q && out_free);
   assign is_last  = (count_q == (pts_q - PTS_W'(1)));

   always_comb begin
      state_d      = state_q;
      pts_d        = pts_q;
      count_d      = count_q;
      size_d       = size_q;
      inverse_d    = inverse_q;
      sink_valid_d = sink_valid_q;
      sink_sop_d   = sink_sop_q;
      sink_eop_d   = sink_eop_q;
      sink_real_d  = sink_real_q;
      sink_imag_d  = sink_imag_q;
      gap_d        = gap_q;
      pad_d        = pad_q;
      err_size_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               if (lut_legal) begin
                  pts_d     = lut_pts;
                  size_d    = req_size;
                  inverse_d = req_inverse;
                  count_d   = '0;
                  pad_d     = 1'b0;
                  state_d   = ST_SEND;
               end else begin
                  err_size_d = 1'b1;
               end
            end
         end

         ST_SEND: begin
            if (take) begin
               sink_valid_d = 1'b1;
               sink_sop_d   = (count_q == '0);
               sink_eop_d   = is_last;
               sink_real_d  = pad_q ? '0 : in_real;
               sink_imag_d  = pad_q ? '0 : in_imag;
               count_d      = count_q + PTS_W'(1);
               if (is_last) begin
                  pad_d   = 1'b0;
                  state_d = ST_DRAIN;
               end else if (in_hs && last_flag) begin
                  pad_d = 1'b1;
               end
            end else if (sink_ready) begin
               // Beat consumed (or register already empty) with nothing new.
               sink_valid_d = 1'b0;
               sink_sop_d   = 1'b0;
               sink_eop_d   = 1'b0;
            end
         end

         ST_DRAIN: begin
            // Only the eop beat can be pending here.
            if (sink_valid_q && sink_ready) begin
               sink_valid_d = 1'b0;
               sink_sop_d   = 1'b0;
               sink_eop_d   = 1'b0;
               gap_d        = GAP_LOAD;
               state_d      = (GAP_MIN == 0) ? ST_IDLE : ST_GAP;
            end
         end

         ST_GAP: begin
            if (gap_q == 8'd0) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Registered so that it reads 0 in the cycle right after reset.
      req_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pts_q        <= '0;
         count_q      <= '0;
         size_q       <= '0;
         inverse_q    <= 1'b0;
         sink_valid_q <= 1'b0;
         sink_sop_q   <= 1'b0;
         sink_eop_q   <= 1'b0;
         sink_real_q  <= '0;
         sink_imag_q  <= '0;
         gap_q        <= '0;
         err_size_q   <= 1'b0;
         pad_q        <= 1'b0;
         req_ready_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pts_q        <= pts_d;
         count_q      <= count_d;
         size_q       <= size_d;
         inverse_q    <= inverse_d;
         sink_valid_q <= sink_valid_d;
         sink_sop_q   <= sink_sop_d;
         sink_eop_q   <= sink_eop_d;
         sink_real_q  <= sink_real_d;
         sink_imag_q  <= sink_imag_d;
         gap_q        <= gap_d;
         err_size_q   <= err_size_d;
         pad_q        <= pad_d;
         req_ready_q  <= req_ready_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign sink_valid = sink_valid_q;
   assign sink_sop   = sink_sop_q;
   assign sink_eop   = sink_eop_q;
   assign sink_real  = sink_real_q;
   assign sink_imag  = sink_imag_q;
   assign size       = size_q;
   assign inverse    = inverse_q;
   assign busy       = (state_q != ST_IDLE);
   assign err_size   = err_size_q;

endmodule : dft_sink_framer
`default_nettype wire

// File: tb/tb_dft_sink_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dft_sink_framer
// Description : Directed self-checking bench for dft_sink_framer. A ramp
//               source feeds the upstream port (real = n, imag = n + 1000);
//               every sink handshake is recorded and each scenario task
//               checks frame length, sop/eop placement, data order, stall
//               stability, gap timing, error pulses and reset abort.
// Options     : DFT_FRAMER_PAD_EN - also exercises the zero-padding path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dft_sink_framer;

   localparam int DW  = 18;
   localparam int GAP = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [5:0]    req_size;
   logic          req_inverse;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_real;
   logic [DW-1:0] in_imag;
`ifdef DFT_FRAMER_PAD_EN
   logic          in_last;
`endif
   logic          sink_valid;
   logic          sink_ready;
   logic          sink_sop;
   logic          sink_eop;
   logic [DW-1:0] sink_real;
   logic [DW-1:0] sink_imag;
   logic [5:0]    size;
   logic          inverse;
   logic          busy;
   logic          err_size;

   always #5 clk = ~clk;

   dft_sink_framer #(.DW(DW), .GAP_MIN(GAP)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_size    (req_size),
      .req_inverse (req_inverse),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_real     (in_real),
      .in_imag     (in_imag),
`ifdef DFT_FRAMER_PAD_EN
      .in_last     (in_last),
`endif
      .sink_valid  (sink_valid),
      .sink_ready  (sink_ready),
      .sink_sop    (sink_sop),
      .sink_eop    (sink_eop),
      .sink_real   (sink_real),
      .sink_imag   (sink_imag),
      .size        (size),
      .inverse     (inverse),
      .busy        (busy),
      .err_size    (err_size)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Stimulus state
   int         src_cnt  = 0;
   bit         src_on   = 0;
   bit         rdy_rand = 0;
   bit         req_pend = 0;
   logic [5:0] req_code = '0;
   bit         req_inv  = 0;
   int         pad_at   = -1;
   int         base     = 0;
   logic [5:0] exp_size = '0;

   // Recorded observations
   int got_real[$];
   int got_imag[$];
   bit got_sop[$];
   bit got_eop[$];
   int eop_cyc;
   int stall_bad;
   int size_bad;
   int err_seen;
   int valid_seen;
   int in_late;
   bit prev_stall;
   logic [2*DW+2:0] prev_snap;

   task automatic clear_rec();
      got_real.delete();
      got_imag.delete();
      got_sop.delete();
      got_eop.delete();
      eop_cyc    = -1;
      stall_bad  = 0;
      size_bad   = 0;
      err_seen   = 0;
      valid_seen = 0;
      in_late    = 0;
      prev_stall = 0;
      base       = src_cnt;
   endtask

   // One clock: drive inputs on the falling edge, observe 1ns later; the
   // observed values are exactly what the next rising edge will see.
   task automatic step();
      @(negedge clk);
      cyc++;
      req_valid   = req_pend;
      req_size    = req_code;
      req_inverse = req_inv;
      in_valid    = src_on;
      in_real     = DW'(src_cnt);
      in_imag     = DW'(src_cnt + 1000);
`ifdef DFT_FRAMER_PAD_EN
      in_last     = (pad_at >= 0) && ((src_cnt - base) == pad_at);
`endif
      sink_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_stall && ({sink_valid, sink_sop, sink_eop, sink_real, sink_imag} !== prev_snap))
         stall_bad++;
      prev_stall = sink_valid && !sink_ready;
      prev_snap  = {sink_valid, sink_sop, sink_eop, sink_real, sink_imag};
      if (sink_valid) valid_seen++;
      if (err_size) err_seen++;
      if (busy && (size !== exp_size)) size_bad++;
      if (pad_at >= 0 && busy && (src_cnt - base) > pad_at && in_ready) in_late++;
      if (sink_valid && sink_ready) begin
         got_real.push_back(int'(sink_real));
         got_imag.push_back(int'(sink_imag));
         got_sop.push_back(sink_sop);
         got_eop.push_back(sink_eop);
         if (sink_eop) eop_cyc = cyc;
      end
      if (in_valid && in_ready) src_cnt++;
      if (req_valid && req_ready) req_pend = 0;
   endtask

   task automatic run_until_eop(input int budget);
      int n = 0;
      while (eop_cyc < 0 && n < budget) begin
         step();
         n++;
      end
   endtask

   task automatic wait_idle(output int waited);
      waited = 0;
      do begin
         step();
         waited++;
      end while (!req_ready && waited < 100);
   endtask

   // Checks the recorded frame: length, sop only first, eop only last,
   // ramp data (or zeros beyond n_data), and upstream consumption.
   task automatic check_frame(input string tag, input int exp_len, input int n_data);
      int sop_bad = 0;
      int eop_bad = 0;
      int dat_bad = 0;
      n_cmp++;
      if (eop_cyc < 0) begin
         n_bad++;
         $display("FAIL %s_timeout: no eop handshake seen, got %0d beats, exp %0d", tag, got_real.size(), exp_len);
      end
      n_cmp++;
      if (got_real.size() !== exp_len) begin
         n_bad++;
         $display("FAIL %s_len: got %0d beats, exp %0d", tag, got_real.size(), exp_len);
      end
      for (int i = 0; i < got_real.size(); i++) begin
         if (got_sop[i] !== (i == 0)) sop_bad++;
         if (got_eop[i] !== (i == exp_len - 1)) eop_bad++;
         if (i < n_data) begin
            if (got_real[i] !== base + i || got_imag[i] !== base + i + 1000) dat_bad++;
         end else begin
            if (got_real[i] !== 0 || got_imag[i] !== 0) dat_bad++;
         end
      end
      n_cmp++;
      if (sop_bad !== 0) begin
         n_bad++;
         $display("FAIL %s_sop: got %0d misplaced sop flags, exp 0", tag, sop_bad);
      end
      n_cmp++;
      if (eop_bad !== 0) begin
         n_bad++;
         $display("FAIL %s_eop: got %0d misplaced eop flags, exp 0", tag, eop_bad);
      end
      n_cmp++;
      if (dat_bad !== 0) begin
         n_bad++;
         $display("FAIL %s_data: got %0d wrong samples, exp 0", tag, dat_bad);
      end
      n_cmp++;
      if (src_cnt - base !== n_data) begin
         n_bad++;
         $display("FAIL %s_consumed: got %0d upstream samples, exp %0d", tag, src_cnt - base, n_data);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if ({sink_valid, sink_sop, sink_eop, busy, err_size, req_ready, in_ready} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b, exp 0000000",
                  {sink_valid, sink_sop, sink_eop, busy, err_size, req_ready, in_ready});
      end
      n_cmp++;
      if ({sink_real, sink_imag, size, inverse} !== '0) begin
         n_bad++;
         $display("FAIL reset_data: got real %0d imag %0d size %0d inv %0d, exp all 0",
                  sink_real, sink_imag, size, inverse);
      end
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++;
      if ({req_ready, busy} !== 2'b10) begin
         n_bad++;
         $display("FAIL reset_release: got req_ready/busy %b, exp 10", {req_ready, busy});
      end
   endtask

   task automatic test_code0();
      int waited;
      clear_rec();
      exp_size = 6'd0;
      src_on   = 1;
      rdy_rand = 0;
      req_code = 6'd0;
      req_inv  = 1;
      req_pend = 1;
      run_until_eop(200);
      check_frame("c0", 12, 12);
      n_cmp++;
      if (valid_seen !== 12) begin
         n_bad++;
         $display("FAIL c0_valid_cycles: got %0d, exp 12", valid_seen);
      end
      n_cmp++;
      if ({size, inverse} !== {6'd0, 1'b1}) begin
         n_bad++;
         $display("FAIL c0_latched: got size %0d inv %0d, exp size 0 inv 1", size, inverse);
      end
      wait_idle(waited);
      n_cmp++;
      if (cyc - eop_cyc !== GAP + 2) begin
         n_bad++;
         $display("FAIL c0_gap: req_ready after %0d cycles, exp %0d", cyc - eop_cyc, GAP + 2);
      end
   endtask

   task automatic test_code33();
      int waited;
      clear_rec();
      exp_size = 6'd33;
      req_code = 6'd33;
      req_inv  = 0;
      req_pend = 1;
      run_until_eop(3000);
      check_frame("c33", 1200, 1200);
      n_cmp++;
      if (size_bad !== 0) begin
         n_bad++;
         $display("FAIL c33_size_hold: got %0d cycles with size != 33, exp 0", size_bad);
      end
      wait_idle(waited);
   endtask

   task automatic test_stall();
      int waited;
      clear_rec();
      exp_size = 6'd1;
      rdy_rand = 1;
      req_code = 6'd1;
      req_inv  = 1;
      req_pend = 1;
      run_until_eop(600);
      rdy_rand = 0;
      check_frame("stall", 24, 24);
      n_cmp++;
      if (stall_bad !== 0) begin
         n_bad++;
         $display("FAIL stall_hold: got %0d outputs changed under stall, exp 0", stall_bad);
      end
      wait_idle(waited);
   endtask

   task automatic test_bad_size();
      int n = 0;
      int waited;
      clear_rec();
      exp_size = 6'd1;
      req_code = 6'd40;
      req_inv  = 0;
      req_pend = 1;
      while (req_pend && n < 20) begin
         step();
         n++;
      end
      repeat (5) step();
      n_cmp++;
      if (err_seen !== 1) begin
         n_bad++;
         $display("FAIL bad_err_pulse: got %0d err_size cycles, exp 1", err_seen);
      end
      n_cmp++;
      if (valid_seen !== 0) begin
         n_bad++;
         $display("FAIL bad_no_valid: got %0d sink_valid cycles, exp 0", valid_seen);
      end
      n_cmp++;
      if ({size, inverse, busy, req_ready} !== {6'd1, 1'b1, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL bad_hold: got size %0d inv %0d busy %0d req_ready %0d, exp 1 1 0 1",
                  size, inverse, busy, req_ready);
      end
      clear_rec();
      exp_size = 6'd2;
      req_code = 6'd2;
      req_pend = 1;
      run_until_eop(300);
      check_frame("after_bad", 36, 36);
      wait_idle(waited);
   endtask

   task automatic test_abort();
      int n = 0;
      int waited;
      clear_rec();
      exp_size = 6'd29;
      req_code = 6'd29;
      req_inv  = 1;
      req_pend = 1;
      while (got_real.size() < 500 && n < 2000) begin
         step();
         n++;
      end
      n_cmp++;
      if (got_real.size() !== 500) begin
         n_bad++;
         $display("FAIL abort_reach: got %0d beats before reset, exp 500", got_real.size());
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      n_cmp++;
      if ({sink_valid, sink_sop, sink_eop, busy, err_size, req_ready, in_ready} !== 7'b0) begin
         n_bad++;
         $display("FAIL abort_ctrl: got %b, exp 0000000",
                  {sink_valid, sink_sop, sink_eop, busy, err_size, req_ready, in_ready});
      end
      n_cmp++;
      if ({sink_real, sink_imag, size, inverse} !== '0) begin
         n_bad++;
         $display("FAIL abort_data: got real %0d imag %0d size %0d inv %0d, exp all 0",
                  sink_real, sink_imag, size, inverse);
      end
      rst_n = 1'b1;
      clear_rec();
      exp_size = 6'd0;
      req_code = 6'd0;
      req_inv  = 0;
      req_pend = 1;
      run_until_eop(200);
      check_frame("post_abort", 12, 12);
      wait_idle(waited);
   endtask

`ifdef DFT_FRAMER_PAD_EN
   task automatic test_pad();
      int waited;
      clear_rec();
      exp_size = 6'd4;
      pad_at   = 9;
      req_code = 6'd4;
      req_inv  = 0;
      req_pend = 1;
      run_until_eop(400);
      check_frame("pad", 60, 10);
      n_cmp++;
      if (in_late !== 0) begin
         n_bad++;
         $display("FAIL pad_in_ready: got %0d in_ready cycles after in_last, exp 0", in_late);
      end
      pad_at = -1;
      wait_idle(waited);
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, exp completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      req_valid   = 1'b0;
      req_size    = '0;
      req_inverse = 1'b0;
      in_valid    = 1'b0;
      in_real     = '0;
      in_imag     = '0;
`ifdef DFT_FRAMER_PAD_EN
      in_last     = 1'b0;
`endif
      sink_ready  = 1'b1;

      test_reset();
      test_code0();
      test_code33();
      test_stall();
      test_bad_size();
      test_abort();
`ifdef DFT_FRAMER_PAD_EN
      test_pad();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_dft_sink_framer
`default_nettype wire
